// File: rtl/uart_tx_ext.sv
// UART transmitter with a TX FIFO and runtime frame format (5-8 data bits, parity, 1/2 stop bits).
// Latency: txd falls one clock after the FIFO head is popped; each line bit lasts P+1 clocks.
// Backpressure: tx_ready_o drops while the FIFO is full; pushes are dropped while full or flushing.

// Generic synchronous FIFO with flush and occupancy count.
// Latency: pushed data is visible at the head on the next clock.
// Backpressure: push_rdy low when full; flush wins over a same-cycle push.
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  output logic                     push_rdy,
  input  logic                     pop_rdy,
  output logic                     pop_vld,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign push_rdy = (count != (AW+1)'(DEPTH));
  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign push     = push_vld & push_rdy & ~flush;
  assign pop      = pop_rdy & pop_vld;

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks push minus pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// UART transmitter top: FIFO-fed frame serializer driving the txd pin.
// Latency: one clock from pop to start bit; frames run back-to-back while data is queued.
// Backpressure: tx_ready_o mirrors FIFO not-full.
module uart_tx_ext #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_bit_period_i,
  input  logic [15:0]                   bit_period_i,
  input  logic [1:0]                    cfg_data_bits_i,
  input  logic                          cfg_parity_en_i,
  input  logic                          cfg_parity_odd_i,
  input  logic                          cfg_stop2_i,
  input  logic                          tx_valid_i,
  input  logic [7:0]                    tx_data_i,
  output logic                          tx_ready_o,
  input  logic                          fifo_flush_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          uart_txd,
  output logic                          uart_tx_busy
);
  localparam logic [15:0] DEFAULT_BIT_PERIOD = 16'(CLK_FREQ / BAUD_RATE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      state;
  logic [15:0] bit_period_r;
  logic [15:0] period_l;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [2:0]  last_idx;
  logic [7:0]  data_r;
  logic        par_en_l;
  logic        par_odd_l;
  logic        stop2_l;
  logic        stop_second;
  logic        txd_r;
  logic        fifo_vld;
  logic [7:0]  fifo_dat;
  logic        start_frame;
  logic        stop_done;

  uart_tx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (fifo_flush_i),
    .push_vld (tx_valid_i),
    .push_dat (tx_data_i),
    .push_rdy (tx_ready_o),
    .pop_rdy  (start_frame),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_dat),
    .count    (fifo_count_o)
  );

  // Last stop bit time expires this clock.
  assign stop_done   = (state == S_STOP) && (cnt == '0) && (!stop2_l || stop_second);
  // Pop from idle, or straight out of the final stop bit for gapless frames.
  assign start_frame = fifo_vld && ((state == S_IDLE) || stop_done);

  assign uart_txd     = txd_r;
  assign uart_tx_busy = (state != S_IDLE) || (fifo_count_o != '0);

  // Runtime bit period; only sampled by the FSM at frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  bit_period_r <= DEFAULT_BIT_PERIOD;
    else if (wr_bit_period_i) bit_period_r <= bit_period_i;
  end

  // Frame FSM: each line bit holds for period_l+1 clocks via a down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      txd_r       <= 1'b1;
      cnt         <= '0;
      period_l    <= DEFAULT_BIT_PERIOD;
      idx         <= '0;
      last_idx    <= 3'd7;
      data_r      <= '0;
      par_en_l    <= 1'b0;
      par_odd_l   <= 1'b0;
      stop2_l     <= 1'b0;
      stop_second <= 1'b0;
    end else begin
      case (state)
        S_IDLE: txd_r <= 1'b1;
        S_START: begin
          if (cnt == '0) begin
            state <= S_DATA;
            idx   <= '0;
            txd_r <= data_r[0];
            cnt   <= period_l;
          end else cnt <= cnt - 16'd1;
        end
        S_DATA: begin
          if (cnt == '0) begin
            cnt <= period_l;
            if (idx == last_idx) begin
              if (par_en_l) begin
                state <= S_PARITY;
                txd_r <= (^data_r) ^ par_odd_l;
              end else begin
                state       <= S_STOP;
                txd_r       <= 1'b1;
                stop_second <= 1'b0;
              end
            end else begin
              idx   <= idx + 3'd1;
              txd_r <= data_r[idx + 3'd1];
            end
          end else cnt <= cnt - 16'd1;
        end
        S_PARITY: begin
          if (cnt == '0) begin
            state       <= S_STOP;
            txd_r       <= 1'b1;
            stop_second <= 1'b0;
            cnt         <= period_l;
          end else cnt <= cnt - 16'd1;
        end
        S_STOP: begin
          if (cnt == '0) begin
            if (stop2_l && !stop_second) begin
              stop_second <= 1'b1;
              cnt         <= period_l;
            end else begin
              state <= S_IDLE;
              txd_r <= 1'b1;
            end
          end else cnt <= cnt - 16'd1;
        end
        default: begin
          state <= S_IDLE;
          txd_r <= 1'b1;
        end
      endcase

      // Frame start overrides the above: latch data (masked to N bits so the
      // parity XOR covers only sent bits), format and period for the whole frame.
      if (start_frame) begin
        state     <= S_START;
        txd_r     <= 1'b0;
        cnt       <= bit_period_r;
        period_l  <= bit_period_r;
        data_r    <= fifo_dat & (8'hFF >> (2'd3 - cfg_data_bits_i));
        last_idx  <= {1'b1, cfg_data_bits_i};
        par_en_l  <= cfg_parity_en_i;
        par_odd_l <= cfg_parity_odd_i;
        stop2_l   <= cfg_stop2_i;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_ext.sv
// Directed testbench for uart_tx_ext: table of single-frame formats plus
// hand-written sequences for FIFO fill, mid-frame period change, flush and reset.
module tb_uart_tx_ext;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_bit_period_i;
  logic [15:0] bit_period_i;
  logic [1:0]  cfg_data_bits_i;
  logic        cfg_parity_en_i;
  logic        cfg_parity_odd_i;
  logic        cfg_stop2_i;
  logic        tx_valid_i;
  logic [7:0]  tx_data_i;
  logic        tx_ready_o;
  logic        fifo_flush_i;
  logic [4:0]  fifo_count_o;
  logic        uart_txd;
  logic        uart_tx_busy;

  int tests = 0;
  int fails = 0;
  bit exp_q[$];

  typedef struct {
    string      name;
    int         p;
    logic [1:0] db;
    logic       pe;
    logic       po;
    logic       s2;
    logic [7:0] dat;
    string      bits;   // expected line bits in transmission order
  } vec_t;

  vec_t vecs[6];

  uart_tx_ext #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .FIFO_DEPTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_bit_period_i  (wr_bit_period_i),
    .bit_period_i     (bit_period_i),
    .cfg_data_bits_i  (cfg_data_bits_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_odd_i (cfg_parity_odd_i),
    .cfg_stop2_i      (cfg_stop2_i),
    .tx_valid_i       (tx_valid_i),
    .tx_data_i        (tx_data_i),
    .tx_ready_o       (tx_ready_o),
    .fifo_flush_i     (fifo_flush_i),
    .fifo_count_o     (fifo_count_o),
    .uart_txd         (uart_txd),
    .uart_tx_busy     (uart_tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_cfg(input int p, input logic [1:0] db, input logic pe,
                         input logic po, input logic s2);
    @(posedge clk); #1;
    bit_period_i     = 16'(p);
    wr_bit_period_i  = 1'b1;
    cfg_data_bits_i  = db;
    cfg_parity_en_i  = pe;
    cfg_parity_odd_i = po;
    cfg_stop2_i      = s2;
    @(posedge clk); #1;
    wr_bit_period_i  = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk); #1;
    tx_valid_i = 1'b1;
    tx_data_i  = b;
    @(posedge clk); #1;
    tx_valid_i = 1'b0;
  endtask

  // Returns at the first falling-edge sample where txd is low.
  task automatic wait_fall(input string name);
    int n = 0;
    while (uart_txd !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (uart_txd !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL %s_start: got txd %0b expected 0 within 200 clk", name, uart_txd);
    end
  endtask

  // 8N1 frame, each line bit repeated p+1 samples.
  task automatic add_frame8(input logic [7:0] b, input int p);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int r = 0; r <= p; r++) exp_q.push_back(f[k]);
  endtask

  // Called at the sample where the start bit was seen; compares every clock
  // of the expected stream, then requires busy to drop on the next clock.
  task automatic check_stream(input string name);
    int n;
    int bad;
    int first;
    int got_v;
    n = exp_q.size();
    bad = 0;
    first = -1;
    got_v = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (uart_txd !== exp_q[i] || uart_tx_busy !== 1'b1) begin
        if (first < 0) begin
          first = i;
          got_v = {30'd0, uart_tx_busy, uart_txd};
        end
        bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s_bits: %0d bad clocks, first at %0d got busy/txd %0d expected busy=1 txd=%0b",
               name, bad, first, got_v, exp_q[first]);
    end
    @(negedge clk);
    chk({name, "_busy_drop"}, int'(uart_tx_busy), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int bad;
    byte c;

    vecs[0] = '{"8N1_55", 3, 2'd3, 1'b0, 1'b0, 1'b0, 8'h55, "0101010101"};
    vecs[1] = '{"7E2_41", 1, 2'd2, 1'b1, 1'b0, 1'b1, 8'h41, "01000001011"};
    vecs[2] = '{"5O1_FF", 1, 2'd0, 1'b1, 1'b1, 1'b0, 8'hFF, "01111101"};
    vecs[3] = '{"6N1_A5", 0, 2'd1, 1'b0, 1'b0, 1'b0, 8'hA5, "01010011"};
    vecs[4] = '{"8E1_80", 2, 2'd3, 1'b1, 1'b0, 1'b0, 8'h80, "00000000111"};
    vecs[5] = '{"8O2_00", 0, 2'd3, 1'b1, 1'b1, 1'b1, 8'h00, "000000000111"};

    rst = 1'b1;
    wr_bit_period_i = 1'b0; bit_period_i = '0;
    cfg_data_bits_i = 2'd3; cfg_parity_en_i = 1'b0; cfg_parity_odd_i = 1'b0; cfg_stop2_i = 1'b0;
    tx_valid_i = 1'b0; tx_data_i = '0; fifo_flush_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_txd", int'(uart_txd), 1);
    chk("reset_busy", int'(uart_tx_busy), 0);
    chk("reset_count", int'(fifo_count_o), 0);
    chk("reset_ready", int'(tx_ready_o), 1);
    rst = 1'b0;

    // Single-frame format table.
    for (int v = 0; v < 6; v++) begin
      set_cfg(vecs[v].p, vecs[v].db, vecs[v].pe, vecs[v].po, vecs[v].s2);
      for (int k = 0; k < vecs[v].bits.len(); k++) begin
        c = vecs[v].bits[k];
        for (int r = 0; r <= vecs[v].p; r++) exp_q.push_back(c == 8'd49);
      end
      push(vecs[v].dat);
      wait_fall(vecs[v].name);
      check_stream(vecs[v].name);
    end

    // FIFO fill while busy: 16 of 17 pushes accepted, 17 frames back-to-back.
    set_cfg(3, 2'd3, 1'b0, 1'b0, 1'b0);
    add_frame8(8'h30, 3);
    for (int j = 1; j <= 16; j++) add_frame8(8'(8'h30 + j * 7), 3);
    push(8'h30);
    wait_fall("fill");
    fork
      begin
        for (int j = 1; j <= 17; j++) begin
          @(posedge clk); #1;
          if (j == 17) begin
            chk("fill_count_full", int'(fifo_count_o), 16);
            chk("fill_ready_low", int'(tx_ready_o), 0);
          end
          tx_valid_i = 1'b1;
          tx_data_i  = 8'(8'h30 + j * 7);
        end
        @(posedge clk); #1;
        tx_valid_i = 1'b0;
        chk("fill_push17_dropped", int'(fifo_count_o), 16);
      end
      check_stream("fill");
    join

    // Period change mid-frame applies to the next frame only.
    set_cfg(3, 2'd3, 1'b0, 1'b0, 1'b0);
    add_frame8(8'h0F, 3);
    add_frame8(8'hF0, 9);
    push(8'h0F);
    wait_fall("period");
    fork
      begin
        push(8'hF0);
        repeat (8) @(posedge clk);
        #1;
        bit_period_i    = 16'd9;
        wr_bit_period_i = 1'b1;
        @(posedge clk); #1;
        wr_bit_period_i = 1'b0;
      end
      check_stream("period");
    join

    // Flush mid-frame with a same-cycle push: frame in flight completes, nothing else.
    set_cfg(3, 2'd3, 1'b0, 1'b0, 1'b0);
    push(8'hFF);
    wait_fall("flush");
    @(negedge clk); tx_valid_i = 1'b1; tx_data_i = 8'h01;
    @(negedge clk); tx_data_i = 8'h02;
    @(negedge clk); tx_data_i = 8'h77; fifo_flush_i = 1'b1;
    @(negedge clk); tx_valid_i = 1'b0; fifo_flush_i = 1'b0;
    chk("flush_count", int'(fifo_count_o), 0);
    chk("flush_busy_inflight", int'(uart_tx_busy), 1);
    n = 4;
    while (uart_tx_busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("flush_frame_len", n, 40);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) bad++;
    end
    chk("flush_no_more_frames", bad, 0);

    // Async reset mid-DATA with three bytes queued.
    push(8'h00);
    wait_fall("reset");
    push(8'h00); push(8'h00); push(8'h00);
    @(negedge clk);
    chk("reset_queued3", int'(fifo_count_o), 3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_txd", int'(uart_txd), 1);
    chk("midrst_busy", int'(uart_tx_busy), 0);
    chk("midrst_count", int'(fifo_count_o), 0);
    chk("midrst_ready", int'(tx_ready_o), 1);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) bad++;
    end
    chk("midrst_no_frames", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
